mem_port_master: RTL and testbench

Initiator side of the CPU's 32 x 16 word-memory port. Accepts one read or write request at a time from the pipeline's memory stage over a valid/ready handshake, sequences the memory's level-sensitive `rd`/`wr` strobes with stable address and data around them, captures read data, and returns a single-cycle response. Sits between the memory-stage control logic and the shared instruction/data memory. Guarantees every access produces a clean strobe rising edge, because the memory responds on strobe edges rather than on the clock.

---
 rtl/mem_port_master.sv | 105 ++++++++++
 tb/tb_mem_port_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// Initiator for the 32 x 16 word-memory port: one access at a time, SETUP/STROBE/DONE
// sequencing so every access presents a clean low-to-high strobe edge to the memory.
module mem_port_master #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic          resp_we,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic          we, we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] rdata_d;
    logic          ready_d;
    logic          rd_d;
    logic          wr_d;
    logic          valid_d;
    logic          resp_we_d;

    // State and all outputs registered; output values are decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            we          <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;
            resp_rdata  <= '0;
            req_ready   <= 1'b1;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            resp_valid  <= 1'b0;
            resp_we     <= 1'b0;
        end else begin
            state       <= state_d;
            we          <= we_d;
            mem_address <= addr_d;
            mem_in      <= wdata_d;
            resp_rdata  <= rdata_d;
            req_ready   <= ready_d;
            mem_rd      <= rd_d;
            mem_wr      <= wr_d;
            resp_valid  <= valid_d;
            resp_we     <= resp_we_d;
        end
    end

    // Next-state, request capture and read-data capture
    always_comb begin
        state_d = state;
        we_d    = we;
        addr_d  = mem_address;
        wdata_d = mem_in;
        rdata_d = resp_rdata;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                // mem_out is only valid while mem_rd is high, i.e. during this state
                if (!we) begin
                    rdata_d = mem_out;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d   = (state_d == IDLE);
        rd_d      = (state_d == STROBE) && !we_d;
        wr_d      = (state_d == STROBE) && we_d;
        valid_d   = (state_d == DONE);
        resp_we_d = (state_d == DONE) && we_d;
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Randomized self-checking bench for mem_port_master against a behavioural strobe-driven
// memory and a shadow reference memory with per-cycle expectations of the access sequence.
module tb_mem_port_master;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_we;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] mem_address;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_in;
    logic [DW-1:0] mem_out;

    mem_port_master #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rdata (resp_rdata),
        .mem_address(mem_address),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_in     (mem_in),
        .mem_out    (mem_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_accept = 0;
    int gap     = 100;

    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] exp_rdata;

    always @(posedge clk) cyc++;

    // Memory device: writes on the rising edge of mem_wr, drives data only while mem_rd is high
    always @(posedge mem_wr) mem[mem_address] = mem_in;
    assign mem_out = mem_rd ? mem[mem_address] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Strobes never overlap and every strobe is preceded by at least two low cycles
    always @(negedge clk) begin
        check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (mem_rd || mem_wr) begin
            check("strobe_gap", 32'(gap >= 2), 32'd1);
            gap = 0;
        end else if (gap < 100) begin
            gap++;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_strobes"}, 32'({mem_rd, mem_wr}), 32'd0);
    endtask

    // One access; called and returns on a negedge. Returns at the DONE-cycle negedge.
    task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input bit hold, input int exp_spacing);
        int cnt;
        cnt = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (exp_spacing > 0) check("accept_spacing", 32'(cyc - last_accept), 32'(exp_spacing));
        last_accept = cyc;

        @(negedge clk);
        if (hold) begin
            req_we    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        check("setup_ready", 32'(req_ready), 32'd0);
        check("setup_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        check("setup_valid", 32'(resp_valid), 32'd0);
        check("setup_addr", 32'(mem_address), 32'(addr));
        check("setup_wdata", 32'(mem_in), 32'(wd));

        @(negedge clk);
        check("strobe_rd", 32'(mem_rd), 32'(!we));
        check("strobe_wr", 32'(mem_wr), 32'(we));
        check("strobe_addr", 32'(mem_address), 32'(addr));
        check("strobe_wdata", 32'(mem_in), 32'(wd));
        check("strobe_valid", 32'(resp_valid), 32'd0);
        if (we) ref_mem[addr] = wd;
        else    exp_rdata = ref_mem[addr];

        @(negedge clk);
        check("done_valid", 32'(resp_valid), 32'd1);
        check("done_we", 32'(resp_we), 32'(we));
        check("done_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        check("done_rdata", 32'(resp_rdata), 32'(exp_rdata));
        check("done_ready", 32'(req_ready), 32'd0);
        check("done_addr", 32'(mem_address), 32'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < int'(NW); i++) begin
            v = DW'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[0] = 16'd3; ref_mem[0] = 16'd3;
        mem[1] = 16'd1; ref_mem[1] = 16'd1;
        mem[2] = 16'd3; ref_mem[2] = 16'd3;
        exp_rdata = '0;

        // Reset with a request present: must not be accepted
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("reset_idle");
            check("reset_resp_we", 32'(resp_we), 32'd0);
            check("reset_addr", 32'(mem_address), 32'd0);
            check("reset_wdata", 32'(mem_in), 32'd0);
            check("reset_rdata", 32'(resp_rdata), 32'd0);
        end

        // Single read of word 0, then data must persist after the memory releases mem_out
        access(1'b0, 5'd0, 16'h1234, 1'b0, 0);
        check("read0_value", 32'(resp_rdata), 32'd3);
        @(negedge clk);
        check("read0_mem_released", 32'(mem_out), 32'd0);
        check("read0_hold", 32'(resp_rdata), 32'd3);
        check_idle("after_read0");

        // Write then read-back
        access(1'b1, 5'd20, 16'hA5C3, 1'b0, 0);
        check("write_keeps_rdata", 32'(resp_rdata), 32'd3);
        @(negedge clk);
        access(1'b0, 5'd20, 16'h0000, 1'b0, 0);
        check("readback_20", 32'(resp_rdata), 32'hA5C3);
        @(negedge clk);

        // Back-to-back stream with req_valid held
        access(1'b0, 5'd0, 16'h0, 1'b1, 0);
        check("stream_0", 32'(resp_rdata), 32'd3);
        access(1'b0, 5'd1, 16'h0, 1'b1, 4);
        check("stream_1", 32'(resp_rdata), 32'd1);
        access(1'b0, 5'd2, 16'h0, 1'b1, 4);
        check("stream_2", 32'(resp_rdata), 32'd3);
        req_valid = 1'b0;
        @(negedge clk);

        // Reset during STROBE of a write to address 5
        v = DW'($urandom);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd5; req_wdata = v;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_setup_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("abort_strobe_wr", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[5] = v;
        exp_rdata  = '0;
        check_idle("abort_reset");
        check("abort_addr", 32'(mem_address), 32'd0);
        check("abort_wdata", 32'(mem_in), 32'd0);
        check("abort_rdata", 32'(resp_rdata), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("abort_after");
        end

        // Boundary addresses
        access(1'b0, 5'd31, 16'h0, 1'b0, 0);
        @(negedge clk);
        access(1'b0, 5'd0, 16'h0, 1'b0, 0);
        check("boundary_0", 32'(resp_rdata), 32'd3);
        @(negedge clk);

        // Randomized traffic against the shadow memory
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom), AW'($urandom), DW'($urandom), 1'b0, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
